sync_fifo_flags: RTL
====================

# sync_fifo_flags

Parametrised single-clock FIFO, the successor to the team's fixed 4x4 TinyTapeout FIFO. It generalises data width and depth and adds programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain and serves as the buffering primitive for the next tile wrappers.

## Interface
- WIDTH, 8: data word width in bits, ≥1
- DEPTH, 8: number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-1: almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH
- AE_LEVEL, 1: almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- wr_data  in  WIDTH  write word
- rd_en  in  1  read (pop) request
- rd_data  out  WIDTH  read word
- rd_valid  out  1  rd_data carries a popped word (mode-dependent, see Configuration)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected
- clr_err  in  1  synchronous clear of overflow/underflow

## Operation
- Storage: DEPTH x WIDTH array, not reset; write pointer and read pointer are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- rd_acc = rd_en & ~empty. wr_acc = wr_en & (~full | rd_acc). A write into a full FIFO succeeds when a read is accepted in the same cycle.
- count updates by +1 (wr_acc only), −1 (rd_acc only), or 0 (both or neither).
- full, empty, almost_full, and almost_empty are decoded from the registered count, so they carry no combinational path from wr_en or rd_en.
- overflow sets on wr_en & ~wr_acc. underflow sets on rd_en & empty. Both are sticky until clr_err or reset. If clr_err coincides with a new error event, set wins.
- Reset (any time, including mid-transfer) immediately forces pointers and count to 0, empty=1, almost_empty=1, full=0, almost_full=0 (1 if AF_LEVEL==0 is illegal, so 0), overflow=0, underflow=0, rd_valid=0, rd_data=0. Stored data is discarded.

## Timing
- A write accepted at edge N is visible in count/empty/flags after edge N. The earliest read is the cycle after.
- Standard mode: a read accepted at edge N presents rd_data and rd_valid=1 after edge N, for exactly one cycle. rd_data holds its value afterward; rd_valid returns to 0. Read latency is 1.
- Back-to-back reads and writes sustain one word per cycle each.
- Simultaneous read and write when empty: the write is accepted, the read is rejected and underflow is set.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through. rd_data combinationally shows the head entry and rd_valid = ~empty. rd_en acts as a pop acknowledge: the next entry appears after the edge. A write into an empty FIFO at edge N makes rd_valid=1 with that word after edge N. rd_data is don't-care while empty (the RTL still drives the array head).
- FIFO_FWFT_EN undefined: standard registered read as described in Timing.

## Test plan
Parameters for all tests: WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
- Reset: rst_n low for 2 cycles, released mid-cycle -> count=0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0, rd_data=0x00.
- Fill and drain: write 0x11, 0x22, 0x33, 0x44 -> almost_full=1 at count=3, full=1 at count=4. A fifth write of 0x55 -> rejected, overflow=1, count stays 4. Then 4 reads -> 0x11, 0x22, 0x33, 0x44 in order, 1-cycle latency, empty=1 after the last read.
- Wrap-around: 10 rounds of write 2 / read 2 with incrementing data -> pointers wrap, data order is preserved, no error flags set.
- Full plus simultaneous read/write: at count=4, wr_en=rd_en=1 with 0xAA -> count stays 4, overflow stays 0, 0xAA is read out last.
- Underflow and clear: rd_en on empty -> underflow=1, rd_valid=0. Pulse clr_err -> underflow=0. Assert clr_err together with rd_en on empty -> underflow stays 1.
- Reset mid-operation: with count=3, pull rst_n low -> immediate return to reset values. After release, writing 0x5A and reading it back returns 0x5A. Repeat with FIFO_FWFT_EN defined and check rd_valid=1 and rd_data=0x5A right after the write edge.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: parameterised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Optional build macro FIFO_FWFT_EN selects first-word-fall-through reads;
// without it reads are registered with one cycle of latency.
module sync_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             rd_acc, wr_acc;

  // Flags come only from the registered count, so no enable-to-flag comb path.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // A pop frees a slot in the same cycle, so a full FIFO can still take a write.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  // Next-state for pointers, occupancy and sticky errors (set beats clear).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr_en & ~wr_acc) ovf_d = 1'b1;
    if (rd_en & empty)   udf_d = 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array; deliberately not reset, contents are stale after reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef FIFO_FWFT_EN
  // Head entry is always visible; rd_en only acknowledges and advances it.
  assign rd_data  = mem_q[rd_ptr_q];
  assign rd_valid = ~empty;
`else
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  // Registered read: data held after the pop, valid pulses for one cycle.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    if (rd_acc) rd_data_d = mem_q[rd_ptr_q];
  end

  // Read output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule
